// File: rtl/dispatch_ctrl_if.sv
// Purpose: fetch/issue/backpressure bundle between fetch, dispatch_ctrl and issue.
// Latency: none; wires only.
// Backpressure: iq_full throttles fetch; rob/rs/lsb_full throttle dispatch.
// Ports: rdy, rollback, if_valid/if_inst/if_pc (fetch side), iq_full,
//        rob_full/rs_full/lsb_full (consumer room flags),
//        inst_valid/inst_to_issue/pc_to_issue (issue side), iq_count (debug).
interface dispatch_ctrl_if #(
    parameter int IQ_LOG = 4
);
    logic              rdy;
    logic              rollback;
    logic              if_valid;
    logic [31:0]       if_inst;
    logic [31:0]       if_pc;
    logic              iq_full;
    logic              rob_full;
    logic              rs_full;
    logic              lsb_full;
    logic              inst_valid;
    logic [31:0]       inst_to_issue;
    logic [31:0]       pc_to_issue;
    logic [IQ_LOG:0]   iq_count;

    // Environment side: fetch, ROB flush and the downstream room flags.
    modport master (
        output rdy, rollback, if_valid, if_inst, if_pc,
        output rob_full, rs_full, lsb_full,
        input  iq_full, inst_valid, inst_to_issue, pc_to_issue, iq_count
    );

    // Dispatch controller side.
    modport slave (
        input  rdy, rollback, if_valid, if_inst, if_pc,
        input  rob_full, rs_full, lsb_full,
        output iq_full, inst_valid, inst_to_issue, pc_to_issue, iq_count
    );
endinterface

// File: rtl/dispatch_ctrl.sv
// Purpose: in-order instruction queue between fetch and issue; pops head when ROB and RS/LSB have room.
// Latency: instruction accepted at cycle T is dispatchable at T+1 (no bypass); inst_valid is combinational.
// Backpressure: iq_full holds fetch; head stalls (blocking younger entries) on rob_full or RS/LSB full.
// Ports: clk, rst (sync, active-high); bus (dispatch_ctrl_if.slave) carries
//        rdy/rollback, fetch push, consumer full flags, issue outputs and iq_count.
module dispatch_ctrl #(
    parameter int IQ_LOG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    dispatch_ctrl_if.slave       bus
);
    localparam int unsigned    DEPTH    = 1 << IQ_LOG;
    localparam logic [IQ_LOG:0] FULL_CNT = (IQ_LOG + 1)'(DEPTH);
    localparam logic [6:0]     OP_LOAD  = 7'b0000011;
    localparam logic [6:0]     OP_STORE = 7'b0100011;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t              mem_q [DEPTH];
    logic [IQ_LOG-1:0]   head_q, head_d;
    logic [IQ_LOG-1:0]   tail_q, tail_d;
    logic [IQ_LOG:0]     count_q, count_d;

    logic   empty;
    logic   full;
    logic   is_mem;
    logic   target_ok;
    logic   pop;
    logic   push;
    entry_t head_ent;

    assign head_ent  = mem_q[head_q];
    assign empty     = (count_q == '0);
    assign full      = (count_q == FULL_CNT);

    // Loads and stores go to the LSB, everything else to the RS; ROB always.
    assign is_mem    = (head_ent.inst[6:0] == OP_LOAD) || (head_ent.inst[6:0] == OP_STORE);
    assign target_ok = !bus.rob_full && (is_mem ? !bus.lsb_full : !bus.rs_full);

    // Full is judged on registered count only: a pop never frees a slot for
    // a push in the same cycle, keeping iq_full free of consumer-flag paths.
    assign pop  = bus.rdy && !rst && !bus.rollback && !empty && target_ok;
    assign push = bus.rdy && !rst && !bus.rollback && bus.if_valid && !full;

    assign bus.iq_full       = full;
    assign bus.inst_valid    = pop;
    assign bus.inst_to_issue = head_ent.inst;
    assign bus.pc_to_issue   = head_ent.pc;
    assign bus.iq_count      = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.rdy) begin
            if (bus.rollback) begin
                head_d  = '0;
                tail_d  = '0;
                count_d = '0;
            end else begin
                if (pop) begin
                    head_d = head_q + IQ_LOG'(1);
                end
                if (push) begin
                    tail_d = tail_q + IQ_LOG'(1);
                end
                count_d = count_q + (IQ_LOG + 1)'(push) - (IQ_LOG + 1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[tail_q] <= '{inst: bus.if_inst, pc: bus.if_pc};
        end
    end
endmodule

// File: tb/tb_dispatch_ctrl.sv
module tb_dispatch_ctrl;
    logic clk;
    logic rst;
    logic rst_next;
    int   checks;
    int   failures;

    dispatch_ctrl_if #(.IQ_LOG(4)) bus ();

    dispatch_ctrl #(.IQ_LOG(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ifv;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        rob;
        logic        rs;
        logic        lsb;
        logic        e_vld;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
        logic [4:0]  e_cnt;
        logic        e_full;
    } vec_t;

    vec_t tbl[$];

    localparam logic [31:0] I_A = 32'h00100093;
    localparam logic [31:0] I_B = 32'h00200113;
    localparam logic [31:0] I_C = 32'h00300193;
    localparam logic [31:0] I_L = 32'h00002283;  // lw
    localparam logic [31:0] I_S = 32'h00502023;  // sw

    function automatic vec_t mk(logic ifv, logic [31:0] inst, logic [31:0] pc,
                                logic rob, logic rs, logic lsb,
                                logic e_vld, logic [31:0] e_inst, logic [31:0] e_pc,
                                logic [4:0] e_cnt, logic e_full);
        vec_t v;
        v.ifv = ifv; v.inst = inst; v.pc = pc;
        v.rob = rob; v.rs = rs; v.lsb = lsb;
        v.e_vld = e_vld; v.e_inst = e_inst; v.e_pc = e_pc;
        v.e_cnt = e_cnt; v.e_full = e_full;
        return v;
    endfunction

    // ALU-class instruction (opcode 0010011) with a distinct rd field.
    function automatic logic [31:0] alu(int k);
        return 32'h00000013 | (32'(k) << 7);
    endfunction

    // One cycle: drive at negedge, sample 1ns later, clock edge follows.
    task automatic step(input string nm, input logic r, input logic rb, input logic ifv,
                        input logic [31:0] inst, input logic [31:0] pc,
                        input logic rob, input logic rs, input logic lsb,
                        input logic e_vld, input logic [31:0] e_inst, input logic [31:0] e_pc,
                        input logic [4:0] e_cnt, input logic e_full);
        logic bad;
        @(negedge clk);
        rst          = rst_next;
        bus.rdy      = r;
        bus.rollback = rb;
        bus.if_valid = ifv;
        bus.if_inst  = inst;
        bus.if_pc    = pc;
        bus.rob_full = rob;
        bus.rs_full  = rs;
        bus.lsb_full = lsb;
        #1;
        checks++;
        bad = (bus.inst_valid !== e_vld) || (bus.iq_count !== e_cnt) || (bus.iq_full !== e_full);
        if (e_vld)
            bad = bad || (bus.inst_to_issue !== e_inst) || (bus.pc_to_issue !== e_pc);
        if (bad) begin
            failures++;
            $display("FAIL %s: got vld=%b inst=%h pc=%h cnt=%0d full=%b, want vld=%b inst=%h pc=%h cnt=%0d full=%b",
                     nm, bus.inst_valid, bus.inst_to_issue, bus.pc_to_issue, bus.iq_count, bus.iq_full,
                     e_vld, e_inst, e_pc, e_cnt, e_full);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        rst_next = 1'b1;
        bus.rdy = 1'b1; bus.rollback = 1'b0; bus.if_valid = 1'b0;
        bus.if_inst = '0; bus.if_pc = '0;
        bus.rob_full = 1'b0; bus.rs_full = 1'b0; bus.lsb_full = 1'b0;

        // Three ALU instructions flow through back to back.
        tbl.push_back(mk(1, I_A, 32'h0, 0,0,0, 0, 0, 0,          0, 0));
        tbl.push_back(mk(1, I_B, 32'h4, 0,0,0, 1, I_A, 32'h0,    1, 0));
        tbl.push_back(mk(1, I_C, 32'h8, 0,0,0, 1, I_B, 32'h4,    1, 0));
        tbl.push_back(mk(0, 0,   0,     0,0,0, 1, I_C, 32'h8,    1, 0));
        tbl.push_back(mk(0, 0,   0,     0,0,0, 0, 0, 0,          0, 0));
        // Load at head blocked by LSB / ROB, then routing per class.
        tbl.push_back(mk(1, I_L, 32'h100, 0,0,1, 0, 0, 0,        0, 0));
        tbl.push_back(mk(1, I_A, 32'h104, 0,0,1, 0, 0, 0,        1, 0));
        tbl.push_back(mk(1, I_S, 32'h108, 0,0,1, 0, 0, 0,        2, 0));
        tbl.push_back(mk(0, 0, 0,         0,0,1, 0, 0, 0,        3, 0));
        tbl.push_back(mk(0, 0, 0,         1,0,0, 0, 0, 0,        3, 0));
        tbl.push_back(mk(0, 0, 0,         0,0,0, 1, I_L, 32'h100, 3, 0));
        tbl.push_back(mk(0, 0, 0,         0,1,0, 0, 0, 0,        2, 0));
        tbl.push_back(mk(0, 0, 0,         0,0,1, 1, I_A, 32'h104, 2, 0));
        tbl.push_back(mk(0, 0, 0,         0,0,1, 0, 0, 0,        1, 0));
        tbl.push_back(mk(0, 0, 0,         0,1,0, 1, I_S, 32'h108, 1, 0));
        tbl.push_back(mk(0, 0, 0,         0,0,0, 0, 0, 0,        0, 0));

        // Reset: outputs quiet while rst high and on the first cycle after.
        step("rst_hold0", 1,0,1, I_A, 32'h0, 0,0,0, 0,0,0, 0,0);
        step("rst_hold1", 1,0,1, I_A, 32'h0, 0,0,0, 0,0,0, 0,0);
        rst_next = 1'b0;
        step("rst_after", 1,0,0, 0, 0, 0,0,0, 0,0,0, 0,0);

        foreach (tbl[i])
            step($sformatf("tbl%0d", i), 1, 0, tbl[i].ifv, tbl[i].inst, tbl[i].pc,
                 tbl[i].rob, tbl[i].rs, tbl[i].lsb,
                 tbl[i].e_vld, tbl[i].e_inst, tbl[i].e_pc, tbl[i].e_cnt, tbl[i].e_full);

        // Fill to 16 with every consumer full; head starts at index 6 so drain wraps.
        for (int i = 0; i < 16; i++)
            step($sformatf("fill%0d", i), 1,0,1, alu(i), 32'h200 + 32'(4*i), 1,1,1,
                 0,0,0, 5'(i), 0);
        step("full_drop", 1,0,1, 32'hDEAD0013, 32'hBAD, 1,1,1, 0,0,0, 16, 1);
        // First drain cycle also offers a push: refused since count was 16.
        for (int i = 0; i < 16; i++)
            step($sformatf("drain%0d", i), 1,0,(i == 0), 32'hDEAD0013, 32'hBAD, 0,0,0,
                 1, alu(i), 32'h200 + 32'(4*i), 5'(16 - i), (i == 0));
        step("drain_empty", 1,0,0, 0,0, 0,0,0, 0,0,0, 0,0);

        // Rollback with 5 queued and a concurrent push.
        for (int i = 0; i < 5; i++)
            step($sformatf("rb_fill%0d", i), 1,0,1, alu(i+1), 32'h300 + 32'(4*i), 1,1,1,
                 0,0,0, 5'(i), 0);
        step("rb_cycle", 1,1,1, alu(9), 32'h3F0, 0,0,0, 0,0,0, 5, 0);
        step("rb_after", 1,0,1, alu(7), 32'h340, 0,0,0, 0,0,0, 0, 0);
        step("rb_newdisp", 1,0,0, 0,0, 0,0,0, 1, alu(7), 32'h340, 1, 0);
        step("rb_empty", 1,0,0, 0,0, 0,0,0, 0,0,0, 0, 0);

        // rdy low freezes everything, including push and rollback.
        step("rdy_push", 1,0,1, alu(3), 32'h400, 0,0,0, 0,0,0, 0, 0);
        for (int i = 0; i < 3; i++)
            step($sformatf("rdy_low%0d", i), 0, (i == 1), 1, alu(4), 32'h404, 0,0,0,
                 0,0,0, 1, 0);
        step("rdy_back", 1,0,0, 0,0, 0,0,0, 1, alu(3), 32'h400, 1, 0);
        step("rdy_empty", 1,0,0, 0,0, 0,0,0, 0,0,0, 0, 0);

        // Simultaneous push/pop at count 8, then reset mid-stream.
        for (int k = 0; k < 8; k++)
            step($sformatf("pp_fill%0d", k), 1,0,1, alu(k), 32'h500 + 32'(4*k), 1,0,0,
                 0,0,0, 5'(k), 0);
        for (int j = 0; j < 4; j++)
            step($sformatf("pp_both%0d", j), 1,0,1, alu(8+j), 32'h500 + 32'(4*(8+j)), 0,0,0,
                 1, alu(j), 32'h500 + 32'(4*j), 8, 0);
        for (int j = 0; j < 4; j++)
            step($sformatf("pp_drain%0d", j), 1,0,0, 0,0, 0,0,0,
                 1, alu(4+j), 32'h500 + 32'(4*(4+j)), 5'(8 - j), 0);
        rst_next = 1'b1;
        step("mid_rst", 1,0,1, alu(20), 32'h600, 0,0,0, 0,0,0, 4, 0);
        rst_next = 1'b0;
        step("post_rst", 1,0,0, 0,0, 0,0,0, 0,0,0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
